// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared state encoding, request fields and defaults for the memory-bus sequencer
package mem_bus_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        GAP   = 2'd2,
        BEAT1 = 2'd3
    } state_t;
    localparam int TO_CYCLES_DEF = 255;
    localparam int TO_W_DEF = 8;
    typedef struct packed {
        logic write;
        logic dword;
        logic ifetch;
    } req_t;
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: per-beat wait counter, expire flags the last allowed wait cycle
module mem_timeout_ctr #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [TO_W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign expire = cnt == TO_W'(TO_CYCLES - 1);
endmodule

// File: rtl/mem_bus_seq.sv
// mem_bus_seq: splits requests into 32-bit memory beats with ready handshake, timeout and BIU strobes
module mem_bus_seq
    import mem_bus_pkg::*;
#(
    parameter int TO_CYCLES = TO_CYCLES_DEF,
    parameter int TO_W = TO_W_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_write,
    input  logic req_dword,
    input  logic req_ifetch,
    output logic busy,
    output logic mem_cs,
    output logic mem_rd,
    output logic mem_wr,
    input  logic mem_ready,
    output logic rd0_en,
    output logic rd1_en,
    output logic ir_en,
    output logic wr0_oe,
    output logic wr1_oe,
    output logic inc_en,
    output logic done,
    output logic bus_err
);
    state_t state, state_nx;
    req_t req_q;
    logic beat, b0_hit, b1_hit, expire, done_nx, err_nx;
    assign beat = state == BEAT0 || state == BEAT1;
    assign b0_hit = state == BEAT0 && mem_ready;
    assign b1_hit = state == BEAT1 && mem_ready;
    // counter is zeroed in IDLE and GAP, the only states that lead into a beat
    mem_timeout_ctr #(.TO_CYCLES(TO_CYCLES), .TO_W(TO_W)) u_to (
        .clk(clk),
        .reset_n(reset_n),
        .clr(state == IDLE || state == GAP),
        .en(beat && !mem_ready),
        .expire(expire)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            req_q <= '0;
            done <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state <= state_nx;
            done <= done_nx;
            bus_err <= err_nx;
            if (state == IDLE && req_valid)
                req_q <= '{write: req_write & ~req_ifetch, dword: req_dword & ~req_ifetch, ifetch: req_ifetch};
        end
    end
    always_comb begin
        state_nx = state;
        done_nx = 1'b0;
        err_nx = 1'b0;
        case (state)
            IDLE: state_nx = req_valid ? BEAT0 : IDLE;
            BEAT0: begin
                state_nx = mem_ready ? (req_q.dword ? GAP : IDLE) : (expire ? IDLE : BEAT0);
                done_nx = mem_ready && !req_q.dword;
                err_nx = !mem_ready && expire;
            end
            GAP: state_nx = BEAT1;
            BEAT1: begin
                state_nx = (mem_ready || expire) ? IDLE : BEAT1;
                done_nx = mem_ready;
                err_nx = !mem_ready && expire;
            end
            default: state_nx = IDLE;
        endcase
    end
    assign req_ready = state == IDLE;
    assign busy = state != IDLE;
    assign mem_cs = beat;
    assign mem_rd = beat && !req_q.write;
    assign mem_wr = beat && req_q.write;
    assign wr0_oe = state == BEAT0 && req_q.write;
    assign wr1_oe = state == BEAT1 && req_q.write;
    // enables coincide with mem_ready so the BIU captures on the completing edge
    assign rd0_en = b0_hit && !req_q.write && !req_q.ifetch;
    assign ir_en = b0_hit && req_q.ifetch;
    assign inc_en = b0_hit && req_q.dword;
    assign rd1_en = b1_hit && !req_q.write;
endmodule
